uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: runtime baud divisor, parity mode and stop-bit count; FIFO-buffered output.
//  Sits between the board rx pin and the command/sensor-report parser.
//  Supersedes the fixed-format receiver: adds per-word parity/frame error flags, overrun detection
//  and a valid/ready output.
// PARAMETERS
//  DATA_W      8    data bits per word (5..9), LSB first on the line
//  DIV_W       16   width of baud divisor input
//  FIFO_DEPTH  4    output FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous, active-high reset
//  rx           in   1             async serial input, idle high
//  baud_div     in   DIV_W         clk cycles per bit minus 1 (50MHz/115200 -> 433); values <3 act as 3
//  parity_mode  in   2             00 none, 01 odd, 10 even, 11 treated as none
//  stop2        in   1             1 = two stop bits checked
//  m_valid      out  1             FIFO head valid
//  m_ready      in   1             consumer accepts head when m_valid&&m_ready
//  m_data       out  DATA_W        head data
//  m_perr       out  1             head word parity error
//  m_ferr       out  1             head word framing error (a stop bit sampled low)
//  overrun      out  1             1-cycle pulse: completed word dropped, FIFO full
//  busy         out  1             FSM not IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; FIFO empty; rx synchroniser flops preset to 1 (no false start).
//  - rx passes a 2-flop synchroniser; falling edge of synced rx in IDLE -> START.
//  - baud_div, parity_mode, stop2 latched at the IDLE->START transition; changes mid-frame ignored.
//  - Bit counter cnt runs 0..div, wraps; sample point at cnt==div>>1 ("mid").
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    START: at mid, sample 1 -> false start, back to IDLE, nothing pushed; sample 0 -> continue.
//    DATA: DATA_W bits, LSB first, one per bit period.
//    PARITY: entered only if mode odd/even. perr = (^data ^ pbit) != (mode==odd).
//    STOP: 1 or 2 bits; any stop sample 0 sets ferr.
//    Return to IDLE at the mid-sample of the last stop bit, not its end, so back-to-back frames resync.
//  - Push {perr,ferr,data} to FIFO in the cycle after the final stop sample; m_valid visible next cycle.
//    Line-in to m_valid latency: last stop mid-sample + 2 clk.
//  - FIFO full at push: word discarded, overrun pulses 1 cycle, FIFO contents untouched.
//  - Push and pop in same cycle while full: pop has priority, push accepted, no overrun.
//  - Framing-error word with data 0 (break) is still pushed; no special handling.
//  - rst mid-frame: frame abandoned, FIFO flushed, outputs 0 next cycle.
// CONFIGURATION
//  `UART_RX_MAJORITY_EN defined:
//    - Each bit (start/data/parity/stop) is a 2-of-3 majority of samples at mid-1, mid, mid+1.
//    - Decision is taken at mid+1; all timing above shifts by one cycle.
//  Undefined:
//    - Single sample at mid.
// STRUCTURE
//  - uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), PAR_NONE/PAR_ODD/PAR_EVEN constants,
//    and a function computing expected parity.
//  - Sub-module uart_rx_fifo: synchronous FIFO, DATA_W+2 wide.
//    Pointers carry an extra wrap bit for full/empty. Show-ahead head output.
//  - Top holds: synchroniser, baud counter, FSM, shift register.
// TESTING
//  - 8N1, div=433: send 0xA5 -> one entry 0xA5, perr=0, ferr=0; m_valid 2 clk after stop mid-sample.
//  - Odd parity: send 0x03 with parity bit 1 -> perr=0.
//    Same frame with parity bit 0 -> perr=1, data 0x03.
//  - stop2=1, second stop bit driven low -> ferr=1; next frame 0x55 received clean.
//  - 200-cycle low glitch on idle line (div=433) -> false start; no push, busy drops, FIFO empty.
//  - m_ready=0, send 5 words with FIFO_DEPTH=4 -> 5th word raises overrun pulse.
//    Drain yields the first 4 words in order.
//  - Back-to-back 0x00,0xFF with no idle gap; rst asserted mid third frame -> 2 words then empty FIFO.
//    With MAJORITY_EN: single-cycle 0 spike at a data-bit mid point is rejected.

Source files
------------

// File: rtl/uart_rx_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the configurable UART receiver:
//                receiver state encoding, parity-mode codes and the
//                expected-parity function.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Parity bit the transmitter should have sent for this data word
    function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg_if
//  Description : Valid/ready output stream of the UART receiver, carrying the
//                data word plus its parity and framing error flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_perr;
    logic              m_ferr;

    modport master (output m_valid, output m_data, output m_perr, output m_ferr, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_perr, input  m_ferr, output m_ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous show-ahead FIFO. Pointers carry an extra wrap bit
//                to tell full from empty. Reports overrun when a push is
//                refused; a pop in the same cycle frees room for the push.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;

    always_comb begin
        empty   = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop   = pop && !empty;
        w_wr    = push && (!w_full || w_pop);
        overrun = push && w_full && !w_pop;
        rdata   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer update; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : UART receiver with runtime baud divisor, parity mode and
//                stop-bit count, per-word parity/framing flags, overrun pulse
//                and FIFO-buffered valid/ready output.
//                Optional macro UART_RX_MAJORITY_EN: each bit is a 2-of-3
//                vote over samples at mid-1, mid, mid+1, decided at mid+1.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             rx,
    input  wire logic [DIV_W-1:0] baud_div,
    input  wire logic [1:0]       parity_mode,
    input  wire logic             stop2,
    uart_rx_cfg_if.master         m,
    output logic                  overrun,
    output logic                  busy
);
    localparam logic [3:0] c_last_bit = 4'(DATA_W - 1);

    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    uart_state_e       r_state, w_next;
    logic [DIV_W-1:0]  r_cnt, r_div, w_mid;
    logic [1:0]        r_mode;
    logic              r_stop2, r_stop_idx;
    logic [3:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_perr, r_ferr, r_push;
    logic              w_fall, w_samp, w_bit, w_par_en;
    logic              w_start, w_shift, w_par_smp, w_stop_smp, w_done;
    logic              w_pop, w_empty;
    logic [DATA_W+1:0] w_head;

    // Two-flop synchroniser plus edge-history flop, preset high so reset never looks like a start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall   = r_rx_prev & ~r_rx_sync;
    assign w_mid    = r_div >> 1;
    assign w_par_en = (r_mode == PAR_ODD) || (r_mode == PAR_EVEN);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synced samples for the 2-of-3 vote
    always_ff @(posedge clk) begin
        if (rst) r_hist <= 2'b11;
        else     r_hist <= {r_hist[0], r_rx_sync};
    end

    assign w_samp = (r_cnt == w_mid + DIV_W'(1));
    assign w_bit  = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_sync) | (r_hist[0] & r_rx_sync);
`else
    assign w_samp = (r_cnt == w_mid);
    assign w_bit  = r_rx_sync;
`endif

    // Bit-period counter: held at 0 in IDLE, wraps at the latched divisor
    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) r_cnt <= '0;
        else if (r_cnt == r_div)    r_cnt <= '0;
        else                        r_cnt <= r_cnt + DIV_W'(1);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state; leaving on the last stop mid-sample lets back-to-back frames resync
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_samp) w_next = w_bit ? IDLE : DATA;
            DATA:    if (w_samp && r_bit_idx == c_last_bit) w_next = w_par_en ? PARITY : STOP;
            PARITY:  if (w_samp) w_next = STOP;
            STOP:    if (w_samp && (!r_stop2 || r_stop_idx)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: per-state sample strobes
    always_comb begin
        busy       = (r_state != IDLE);
        w_start    = (r_state == IDLE)   && w_fall;
        w_shift    = (r_state == DATA)   && w_samp;
        w_par_smp  = (r_state == PARITY) && w_samp;
        w_stop_smp = (r_state == STOP)   && w_samp;
        w_done     = w_stop_smp && (!r_stop2 || r_stop_idx);
    end

    // Frame datapath: config latch at start, shift register, error flags, push strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= DIV_W'(3);
            r_mode     <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_push     <= 1'b0;
        end else begin
            r_push <= w_done;
            if (w_start) begin
                r_div      <= (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;
                r_mode     <= parity_mode;
                r_stop2    <= stop2;
                r_stop_idx <= 1'b0;
                r_bit_idx  <= '0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
            end
            if (w_par_smp) r_perr <= (w_bit != calc_parity(9'(r_shift), r_mode));
            if (w_stop_smp) begin
                if (!w_bit) r_ferr <= 1'b1;
                r_stop_idx <= 1'b1;
            end
        end
    end

    assign w_pop = m.m_valid && m.m_ready;

    uart_rx_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (r_push),
        .wdata   ({r_perr, r_ferr, r_shift}),
        .pop     (w_pop),
        .rdata   (w_head),
        .empty   (w_empty),
        .overrun (overrun)
    );

    assign m.m_valid = !w_empty;
    assign m.m_perr  = w_head[DATA_W+1];
    assign m.m_ferr  = w_head[DATA_W];
    assign m.m_data  = w_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Self-checking bench for uart_rx_cfg with a scoreboard of
//                expected words compared as they leave the output stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Start edge to first m_valid: 2 sync flops + edge flop + mid + L bit periods + push + write
    localparam int LAT_8N1_433 = 5 + 216 + 9 * 434 + MAJ;
    localparam int PUSH_CYC_16 = 5 + 7 + 9 * 16 + MAJ;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        overrun;
    logic        busy;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ovr_cnt = 0;

    uart_rx_cfg_if #(.DATA_W(8)) m_if ();

    uart_rx_cfg #(
        .DATA_W     (8),
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .m           (m_if.master),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        sb_q.push_back(e);
    endtask

    // Drive one frame; spike_bit >= 0 inverts that line bit for one cycle near its middle
    task automatic send_frame(input logic [7:0] d, input int per, input logic par_on,
                              input logic pbit, input logic two_stop, input logic s2val,
                              input int spike_bit);
        logic bits [12];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par_on) begin
            bits[n] = pbit;
            n = n + 1;
        end
        bits[n] = 1'b1;
        n = n + 1;
        if (two_stop) begin
            bits[n] = s2val;
            n = n + 1;
        end
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            if (i == spike_bit) begin
                wait_cyc(per / 2);
                rx = ~bits[i];
                wait_cyc(1);
                rx = bits[i];
                wait_cyc(per - per / 2 - 1);
            end else begin
                wait_cyc(per);
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_if.m_valid) begin
                when = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t0, tv, o0;
        rst         = 1'b1;
        rx          = 1'b1;
        baud_div    = 16'd433;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        m_if.m_ready = 1'b0;

        // Output monitor: compare every accepted word against the scoreboard head
        fork
            forever begin
                @(negedge clk);
                if (!rst && overrun) ovr_cnt++;
                if (!rst && m_if.m_valid && m_if.m_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_word", {24'd0, m_if.m_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("data", {24'd0, m_if.m_data}, {24'd0, e.data});
                        check("perr", {31'd0, m_if.m_perr}, {31'd0, e.perr});
                        check("ferr", {31'd0, m_if.m_ferr}, {31'd0, e.ferr});
                    end
                end
            end
        join_none

        // Reset state
        wait_cyc(5);
        check("rst_valid",   {31'd0, m_if.m_valid}, 0);
        check("rst_data",    {24'd0, m_if.m_data}, 0);
        check("rst_flags",   {30'd0, m_if.m_perr, m_if.m_ferr}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        check("rst_busy",    {31'd0, busy}, 0);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 at div=433, with output latency
        m_if.m_ready = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 434, 1'b0, 1'b0, 1'b0, 1'b1, -1);
            begin
                t0 = cyc;
                wait_valid(6000, tv);
                check("latency_8n1", tv - t0, LAT_8N1_433);
            end
        join
        wait_cyc(10);

        // Glitch on idle line -> false start
        rx = 1'b0;
        wait_cyc(100);
        check("glitch_busy_mid", {31'd0, busy}, 1);
        wait_cyc(100);
        rx = 1'b1;
        wait_cyc(500);
        check("glitch_busy_after", {31'd0, busy}, 0);
        check("glitch_no_word", {31'd0, m_if.m_valid}, 0);

        // Parity modes at div=15
        baud_div    = 16'd15;
        parity_mode = 2'b01;
        push_exp(8'h03, 1'b0, 1'b0);
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        push_exp(8'h03, 1'b1, 1'b0);
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        parity_mode = 2'b10;
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        push_exp(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        parity_mode = 2'b11;
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        parity_mode = 2'b00;
        wait_cyc(20);

        // Two stop bits, second low -> framing error, then a clean frame
        stop2 = 1'b1;
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        rx = 1'b1;
        wait_cyc(20);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        stop2 = 1'b0;
        wait_cyc(20);

        // Config changes mid-frame are ignored
        push_exp(8'hC3, 1'b0, 1'b0);
        fork
            send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
            begin
                wait_cyc(30);
                baud_div    = 16'd40;
                parity_mode = 2'b10;
                stop2       = 1'b1;
            end
        join
        baud_div    = 16'd15;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        wait_cyc(20);

        // Divisor below 3 behaves as 3
        baud_div = 16'd1;
        push_exp(8'h96, 1'b0, 1'b0);
        send_frame(8'h96, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        wait_cyc(10);
        baud_div = 16'd15;

        // Five words into a 4-deep FIFO -> overrun on the fifth, drain in order
        m_if.m_ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) begin
            push_exp(8'h10 + 8'(i), 1'b0, 1'b0);
            send_frame(8'h10 + 8'(i), 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        end
        wait_cyc(5);
        check("ovr_after4", ovr_cnt - o0, 0);
        send_frame(8'hEE, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        wait_cyc(5);
        check("ovr_5th", ovr_cnt - o0, 1);
        m_if.m_ready = 1'b1;
        wait_cyc(20);
        check("drain_empty_sb", sb_q.size(), 0);
        check("drain_valid", {31'd0, m_if.m_valid}, 0);

        // Push and pop in the same cycle while full: push accepted, no overrun
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(8'h20 + 8'(i), 1'b0, 1'b0);
            send_frame(8'h20 + 8'(i), 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        end
        o0 = ovr_cnt;
        push_exp(8'h99, 1'b0, 1'b0);
        fork
            send_frame(8'h99, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
            begin
                wait_cyc(PUSH_CYC_16 - 1);
                m_if.m_ready = 1'b1;
                wait_cyc(1);
                m_if.m_ready = 1'b0;
            end
        join
        wait_cyc(5);
        check("full_pushpop_ovr", ovr_cnt - o0, 0);
        m_if.m_ready = 1'b1;
        wait_cyc(20);
        check("full_pushpop_sb", sb_q.size(), 0);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle spike in the middle of a data bit is voted out
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        wait_cyc(20);
        check("spike_sb", sb_q.size(), 0);
`endif

        // Back-to-back 0x00, 0xFF then reset mid third frame
        m_if.m_ready = 1'b0;
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        rx = 1'b0;
        m_if.m_ready = 1'b1;
        wait_cyc(1);
        m_if.m_ready = 1'b0;
        wait_cyc(40);
        check("b2b_one_left", sb_q.size(), 1);
        check("b2b_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_mid_valid", {31'd0, m_if.m_valid}, 0);
        check("rst_mid_busy",  {31'd0, busy}, 0);
        check("rst_mid_data",  {24'd0, m_if.m_data}, 0);
        sb_q.delete();
        rx = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        m_if.m_ready = 1'b1;
        wait_cyc(400);
        check("post_rst_valid", {31'd0, m_if.m_valid}, 0);
        check("post_rst_busy",  {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
